// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Purpose  : Two-to-one memory arbiter. Merges the instruction-fetch port (A,
//            read-only) and the data port (B, read/write) onto one memory
//            port. One transaction is outstanding at a time; it is latched on
//            acceptance, presented downstream until mem_resp, and the result
//            is returned to the originating port as a one-cycle pulse.
// Ports    : clk, rst_n (async, active-low)
//            Port A : read_a, address_a -> resp_a, rdata_a
//            Port B : read_b, write, wmask, address_b, wdata -> resp_b, rdata_b
//            Memory : mem_read, mem_write, mem_wmask, mem_address, mem_wdata
//                     <- mem_rdata, mem_resp
// Config   : MEM_ARB_ROUND_ROBIN_EN - when defined, contention in IDLE is
//            resolved round-robin; otherwise port B has fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
module mem_port_arbiter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    // Port A (instruction fetch, read-only)
    input  logic                  read_a,
    input  logic [DATA_WIDTH-1:0] address_a,
    output logic                  resp_a,
    output logic [DATA_WIDTH-1:0] rdata_a,
    // Port B (data, read/write)
    input  logic                  read_b,
    input  logic                  write,
    input  logic [3:0]            wmask,
    input  logic [DATA_WIDTH-1:0] address_b,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic                  resp_b,
    output logic [DATA_WIDTH-1:0] rdata_b,
    // Downstream memory port
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [3:0]            mem_wmask,
    output logic [DATA_WIDTH-1:0] mem_address,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_resp
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    // Transaction registers
    logic                  r_own_b;     // 0 = port A owns, 1 = port B owns
    logic                  r_we;
    logic [DATA_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [3:0]            r_wmask;

    logic [DATA_WIDTH-1:0] r_rdata_a;
    logic [DATA_WIDTH-1:0] r_rdata_b;

    logic                  w_req_a;
    logic                  w_req_b;
    logic                  w_grant_b;
    logic                  w_accept;
    logic                  w_busy;
    logic                  w_resp;

    assign w_req_a  = read_a;
    assign w_req_b  = read_b | write;
    assign w_accept = (r_state == S_IDLE) && (w_req_a || w_req_b);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    // Remembers who won the last contended grant; only contention updates
    // it, so a stream of uncontended requests does not disturb the rotation.
    logic r_last_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_b <= 1'b0;
        end else if (w_accept && w_req_a && w_req_b) begin
            r_last_b <= w_grant_b;
        end
    end

    always_comb begin
        w_grant_b = w_req_b && (!w_req_a || !r_last_b);
    end
`else
    always_comb begin
        w_grant_b = w_req_b;
    end
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_req_a || w_req_b) w_state_nxt = S_BUSY;
            S_BUSY:  if (mem_resp)           w_state_nxt = S_RESP;
            S_RESP:                          w_state_nxt = S_IDLE;
            default:                         w_state_nxt = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Transaction capture. Port A is forced to a read with no write data
    // so a stale B write can never leak onto an A transaction. A write on
    // port B overrides a simultaneous read_b.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_own_b <= 1'b0;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_wmask <= '0;
        end else if (w_accept) begin
            r_own_b <= w_grant_b;
            r_we    <= w_grant_b & write;
            r_addr  <= w_grant_b ? address_b : address_a;
            r_wdata <= w_grant_b ? wdata     : '0;
            r_wmask <= w_grant_b ? wmask     : 4'h0;
        end
    end

    // Read data is held until the owner's next read completes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rdata_a <= '0;
            r_rdata_b <= '0;
        end else if ((r_state == S_BUSY) && mem_resp) begin
            if (!r_own_b) begin
                r_rdata_a <= mem_rdata;
            end else if (!r_we) begin
                r_rdata_b <= mem_rdata;
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: decoded from registers only
    // ------------------------------------------------------------------
    assign w_busy      = (r_state == S_BUSY);
    assign w_resp      = (r_state == S_RESP);

    assign mem_read    = w_busy & ~r_we;
    assign mem_write   = w_busy &  r_we;
    assign mem_wmask   = w_busy ? r_wmask : 4'h0;
    assign mem_address = r_addr;
    assign mem_wdata   = r_wdata;

    assign resp_a      = w_resp & ~r_own_b;
    assign resp_b      = w_resp &  r_own_b;
    assign rdata_a     = r_rdata_a;
    assign rdata_b     = r_rdata_b;

endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Randomized scoreboard bench for mem_port_arbiter. A driver issues
//            request rounds and a word-level reference model predicts service
//            order, downstream strobes and returned data; independent
//            monitors compare the memory side and the response side.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        read_a;
    logic [31:0] address_a;
    logic        resp_a;
    logic [31:0] rdata_a;
    logic        read_b;
    logic        write;
    logic [3:0]  wmask;
    logic [31:0] address_b;
    logic [31:0] wdata;
    logic        resp_b;
    logic [31:0] rdata_b;
    logic        mem_read;
    logic        mem_write;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_address;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_resp;

    always #5 clk = ~clk;

    mem_port_arbiter #(.DATA_WIDTH(32)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .read_a      (read_a),
        .address_a   (address_a),
        .resp_a      (resp_a),
        .rdata_a     (rdata_a),
        .read_b      (read_b),
        .write       (write),
        .wmask       (wmask),
        .address_b   (address_b),
        .wdata       (wdata),
        .resp_b      (resp_b),
        .rdata_b     (rdata_b),
        .mem_read    (mem_read),
        .mem_write   (mem_write),
        .mem_wmask   (mem_wmask),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_rdata   (mem_rdata),
        .mem_resp    (mem_resp)
    );

    typedef struct {
        bit          port_b;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wmask;
        logic [31:0] rdata;
    } txn_t;

    txn_t        mem_q[$];
    txn_t        resp_q[$];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] ref_mem[16];
    logic [31:0] dev_mem[16];
    logic [31:0] exp_rdata_a = '0;
    logic [31:0] exp_rdata_b = '0;
    bit          last_b  = 1'b0;
    bit          mon_en  = 1'b0;
    bit          resp_en = 1'b0;
    bit          timed_out = 1'b0;

    task automatic chk(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  m);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (m[b]) r[b*8 +: 8] = wd[b*8 +: 8];
        return r;
    endfunction

    // Reference model: serving a transaction updates memory / the per-port
    // read-data holders and queues what both sides of the DUT should show.
    task automatic model_serve(input bit pb, input bit we, input logic [31:0] a,
                               input logic [31:0] wd, input logic [3:0] m);
        txn_t t;
        t.port_b = pb;
        t.we     = we;
        t.addr   = a;
        t.wdata  = wd;
        t.wmask  = m;
        if (we) begin
            ref_mem[a[5:2]] = merge(ref_mem[a[5:2]], wd, m);
            t.rdata = exp_rdata_b;
        end else begin
            t.rdata = ref_mem[a[5:2]];
            if (pb) exp_rdata_b = t.rdata;
            else    exp_rdata_a = t.rdata;
        end
        mem_q.push_back(t);
        resp_q.push_back(t);
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h0000_0100 + 32'($urandom_range(0, 15)) * 32'd4;
    endfunction

    task automatic do_round();
        int          pat;
        bit          ra, rb, bw, br, first_b, pend_a, pend_b, scrambled;
        logic [31:0] aa, ab, wd;
        logic [3:0]  wm;
        int          budget;
        pat = $urandom_range(0, 5);
        ra  = (pat == 0) || (pat >= 4);
        rb  = (pat != 0);
        bw  = (pat == 2) || (pat == 3) || (pat == 5);
        br  = (pat == 1) || (pat == 3) || (pat == 4) || ((pat == 5) && ($urandom_range(0, 1) == 1));
        aa  = rand_addr();
        ab  = rand_addr();
        wd  = $urandom;
        wm  = 4'($urandom_range(0, 15));
        address_a = aa;
        address_b = ab;
        wdata     = wd;
        wmask     = wm;
        read_a    = ra;
        read_b    = br;
        write     = bw;
        if (ra && rb) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
            first_b = !last_b;
            last_b  = first_b;
`else
            first_b = 1'b1;
`endif
            if (first_b) begin
                model_serve(1'b1, bw, ab, wd, wm);
                model_serve(1'b0, 1'b0, aa, 32'h0, 4'h0);
            end else begin
                model_serve(1'b0, 1'b0, aa, 32'h0, 4'h0);
                model_serve(1'b1, bw, ab, wd, wm);
            end
        end else if (ra) begin
            model_serve(1'b0, 1'b0, aa, 32'h0, 4'h0);
        end else begin
            model_serve(1'b1, bw, ab, wd, wm);
        end
        pend_a    = ra;
        pend_b    = rb;
        scrambled = 1'b0;
        budget    = 60;
        while ((pend_a || pend_b) && budget > 0) begin
            @(negedge clk);
            budget--;
            if (resp_a && pend_a) begin
                read_a = 1'b0;
                pend_a = 1'b0;
            end
            if (resp_b && pend_b) begin
                read_b = 1'b0;
                write  = 1'b0;
                pend_b = 1'b0;
            end
            // Once a lone request is in flight its inputs are don't-care.
            if (!(ra && rb) && !scrambled && (mem_read || mem_write)) begin
                scrambled = 1'b1;
                address_a = $urandom;
                address_b = $urandom;
                wdata     = $urandom;
                wmask     = 4'($urandom_range(0, 15));
            end
        end
        if (pend_a || pend_b) begin
            chk(1'b0, "resp_timeout", {30'd0, pend_b, pend_a}, 32'd0);
            timed_out = 1'b1;
            read_a = 1'b0;
            read_b = 1'b0;
            write  = 1'b0;
        end
    endtask

    // Memory-side monitor
    initial begin
        bit   prev;
        bit   have;
        bit   strobe;
        txn_t cur;
        prev = 1'b0;
        have = 1'b0;
        forever begin
            @(negedge clk);
            if (!mon_en) begin
                prev = 1'b0;
                have = 1'b0;
                continue;
            end
            strobe = mem_read || mem_write;
            if (strobe && !prev) begin
                if (mem_q.size() == 0) begin
                    chk(1'b0, "mem_unexpected", mem_address, 32'd0);
                    have = 1'b0;
                end else begin
                    cur  = mem_q.pop_front();
                    have = 1'b1;
                end
            end
            if (strobe && have) begin
                chk((mem_write == cur.we) && (mem_read == !cur.we), "mem_op",
                    {30'd0, mem_write, mem_read}, {30'd0, cur.we, !cur.we});
                chk(mem_address == cur.addr, "mem_address", mem_address, cur.addr);
                if (cur.we) begin
                    chk(mem_wdata == cur.wdata, "mem_wdata", mem_wdata, cur.wdata);
                    chk(mem_wmask == cur.wmask, "mem_wmask", {28'd0, mem_wmask}, {28'd0, cur.wmask});
                end
            end
            if (!strobe) chk(mem_wmask == 4'h0, "mem_wmask_idle", {28'd0, mem_wmask}, 32'd0);
            prev = strobe;
        end
    end

    // Response-side monitor
    initial begin
        txn_t t;
        forever begin
            @(negedge clk);
            if (mon_en && (resp_a || resp_b)) begin
                if (resp_a && resp_b) begin
                    chk(1'b0, "resp_both", 32'd3, 32'd1);
                end else if (resp_q.size() == 0) begin
                    chk(1'b0, "resp_unexpected", {30'd0, resp_b, resp_a}, 32'd0);
                end else begin
                    t = resp_q.pop_front();
                    chk(resp_b == t.port_b, "resp_port", {31'd0, resp_b}, {31'd0, t.port_b});
                    if (t.port_b) chk(rdata_b == t.rdata, "rdata_b", rdata_b, t.rdata);
                    else          chk(rdata_a == t.rdata, "rdata_a", rdata_a, t.rdata);
                end
            end
        end
    end

    // Downstream memory device with random latency (0..3 extra BUSY cycles)
    initial begin
        int          d;
        logic [31:0] a;
        forever begin
            @(negedge clk);
            if (resp_en && (mem_read || mem_write)) begin
                d = $urandom_range(0, 3);
                repeat (d) @(negedge clk);
                a = mem_address;
                mem_resp = 1'b1;
                if (mem_write) begin
                    dev_mem[a[5:2]] = merge(dev_mem[a[5:2]], mem_wdata, mem_wmask);
                    mem_rdata = $urandom;
                end else begin
                    mem_rdata = dev_mem[a[5:2]];
                end
                @(negedge clk);
                mem_resp  = 1'b0;
                mem_rdata = $urandom;
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        read_a    = 1'b0;
        read_b    = 1'b0;
        write     = 1'b0;
        wmask     = 4'h0;
        address_a = '0;
        address_b = '0;
        wdata     = '0;
        mem_rdata = '0;
        mem_resp  = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ref_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
            dev_mem[i] = (32'(i) * 32'h0101_0101) ^ 32'hA5A5_0000;
        end
        repeat (3) @(negedge clk);
        chk({resp_a, resp_b, mem_read, mem_write, mem_wmask} == 8'd0, "reset_ctrl",
            {24'd0, resp_a, resp_b, mem_read, mem_write, mem_wmask}, 32'd0);
        chk(rdata_a == 32'd0, "reset_rdata_a", rdata_a, 32'd0);
        chk(rdata_b == 32'd0, "reset_rdata_b", rdata_b, 32'd0);
        chk(mem_address == 32'd0 && mem_wdata == 32'd0, "reset_mem_bus", mem_address | mem_wdata, 32'd0);
        rst_n   = 1'b1;
        mon_en  = 1'b1;
        resp_en = 1'b1;
        @(negedge clk);

        for (int r = 0; r < 200; r++) begin
            if (!timed_out) begin
                do_round();
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end
        repeat (4) @(negedge clk);
        chk(mem_q.size() == 0 && resp_q.size() == 0, "queues_drained",
            32'(mem_q.size() + resp_q.size()), 32'd0);

        // Directed: input change mid-BUSY, then reset mid-BUSY and late mem_resp
        mon_en  = 1'b0;
        resp_en = 1'b0;
        @(negedge clk);
        read_a    = 1'b1;
        address_a = 32'h0000_0060;
        @(negedge clk);
        chk(mem_read == 1'b1 && mem_write == 1'b0, "dir_busy_read", {30'd0, mem_write, mem_read}, 32'd1);
        chk(mem_address == 32'h60, "dir_busy_addr", mem_address, 32'h60);
        address_a = 32'h0000_0064;
        @(negedge clk);
        chk(mem_address == 32'h60, "dir_addr_hold", mem_address, 32'h60);
        rst_n = 1'b0;
        #1;
        chk({resp_a, resp_b, mem_read, mem_write, mem_wmask} == 8'd0, "async_rst_ctrl",
            {24'd0, resp_a, resp_b, mem_read, mem_write, mem_wmask}, 32'd0);
        chk(mem_address == 32'd0, "async_rst_addr", mem_address, 32'd0);
        chk(mem_wdata == 32'd0, "async_rst_wdata", mem_wdata, 32'd0);
        chk(rdata_a == 32'd0 && rdata_b == 32'd0, "async_rst_rdata", rdata_a | rdata_b, 32'd0);
        @(negedge clk);
        read_a    = 1'b0;
        rst_n     = 1'b1;
        mem_resp  = 1'b1;
        mem_rdata = 32'h0000_0013;
        @(negedge clk);
        mem_resp  = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk(!resp_a && !resp_b && !mem_read && rdata_a == 32'd0, "late_resp_ignored",
                {29'd0, resp_a, resp_b, mem_read}, 32'd0);
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
